// File: rtl/pet_needs_engine_pkg.sv
// pet_needs_engine_pkg: shared mood codes and width helpers for the pet needs engine.
package pet_needs_engine_pkg;
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_NEUTRAL = 4'd1,
        ST_NEED    = 4'd2,
        ST_SLEEP   = 4'd3,
        ST_DEATH   = 4'd15
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pet_tick_gen.sv
// pet_tick_gen: base-tick prescaler and decay counter.
// TEST_ACCEL_EN adds the shortened test_en timebase.
module pet_tick_gen #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DECAY_TICKS = 10,
    parameter int ACCEL_SHIFT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic test_en,
    output logic tick,
    output logic decay_ev
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

    logic [PW-1:0] presc_q, presc_d, last;
    logic [DW-1:0] dec_q, dec_d;
    logic          restart;

`ifdef TEST_ACCEL_EN
    localparam int ACC_RAW = TICK_DIV >> ACCEL_SHIFT;
    localparam int ACC_DIV = (ACC_RAW < 2) ? 2 : ACC_RAW;
    logic ten_q;

    // a mode switch restarts the prescaler so the first accelerated tick is a full period
    assign restart = test_en != ten_q;
    assign last    = test_en ? PW'(ACC_DIV - 1) : PW'(TICK_DIV - 1);

    always_ff @(posedge clk) begin
        ten_q <= rst ? 1'b0 : test_en;
    end
`else
    logic unused_test;
    assign unused_test = test_en;
    assign restart     = 1'b0;
    assign last        = PW'(TICK_DIV - 1);
`endif

    always_comb begin
        tick     = !restart && presc_q == last;
        decay_ev = tick && dec_q == DW'(DECAY_TICKS - 1);
        presc_d  = (restart || tick) ? '0 : presc_q + 1'b1;
        dec_d    = decay_ev ? '0 : tick ? dec_q + 1'b1 : dec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            dec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            dec_q   <= dec_d;
        end
    end
endmodule

// File: rtl/pet_needs_engine.sv
// pet_needs_engine: saturating need levels with decay/refill and a registered mood FSM.
// TEST_ACCEL_EN enables the accelerated timebase and direct level loading.
module pet_needs_engine
    import pet_needs_engine_pkg::*;
#(
    parameter int NUM_NEEDS   = 3,
    parameter int LVL_W       = 3,
    parameter int TICK_DIV    = 50_000_000,
    parameter int DECAY_TICKS = 10,
    parameter int REFILL_STEP = 2,
    parameter int LOW_THR     = 2,
    parameter int HI_THR      = 5,
    parameter int DEATH_TICKS = 8,
    parameter int ACCEL_SHIFT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_NEEDS-1:0]          refill,
    input  logic                          sleep_req,
    input  logic                          wake_req,
    input  logic                          test_en,
    input  logic                          test_load,
    input  logic [idx_w(NUM_NEEDS)-1:0]   test_sel,
    input  logic [LVL_W-1:0]              test_level,
    output logic [NUM_NEEDS*LVL_W-1:0]    levels,
    output logic [3:0]                    state,
    output logic [idx_w(NUM_NEEDS)-1:0]   need_idx,
    output logic                          tick
);
    localparam int IW = idx_w(NUM_NEEDS);
    localparam int CW = $clog2(DEATH_TICKS + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    state_e           state_q, state_d, eval;
    logic [LVL_W-1:0] lvl_q [NUM_NEEDS];
    logic [LVL_W-1:0] lvl_d [NUM_NEEDS];
    logic [LVL_W-1:0] min_v;
    logic [IW-1:0]    idx_q, idx_d, search_idx;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic             decay_ev, sleeping, any_zero, any_low, all_hi;
    logic             load;
    logic [IW-1:0]    load_sel;
    logic [LVL_W-1:0] load_lvl;

`ifdef TEST_ACCEL_EN
    assign load     = test_load;
    assign load_sel = test_sel;
    assign load_lvl = test_level;
`else
    logic unused_test;
    assign unused_test = ^{test_load, test_sel, test_level};
    assign load        = 1'b0;
    assign load_sel    = '0;
    assign load_lvl    = '0;
`endif

    pet_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .DECAY_TICKS(DECAY_TICKS),
        .ACCEL_SHIFT(ACCEL_SHIFT)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .test_en (test_en),
        .tick    (tick),
        .decay_ev(decay_ev)
    );

    // add first, then step down, then clamp: refill+decay at max stays at max
    function automatic logic [LVL_W-1:0] next_lvl(input logic [LVL_W-1:0] cur, input logic add,
                                                   input logic up, input logic down);
        logic [LVL_W+1:0] s;
        s = {2'b00, cur} + (add ? (LVL_W+2)'(REFILL_STEP) : '0) + {{(LVL_W+1){1'b0}}, up};
        if (down && s != '0) s = s - 1'b1;
        return (s > {2'b00, LVL_MAX}) ? LVL_MAX : s[LVL_W-1:0];
    endfunction

    always_comb begin
        sleeping   = state_q == ST_SLEEP;
        any_zero   = 1'b0;
        any_low    = 1'b0;
        all_hi     = 1'b1;
        min_v      = lvl_q[0];
        search_idx = '0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            lvl_d[i] = next_lvl(lvl_q[i], refill[i] && !sleeping,
                                decay_ev && sleeping && i == 0,
                                decay_ev && !(sleeping && i == 0));
            lvl_d[i] = (load && load_sel == IW'(i)) ? load_lvl : lvl_d[i];
            lvl_d[i] = (state_q == ST_DEATH) ? lvl_q[i] : lvl_d[i];
            any_zero = any_zero | (lvl_q[i] == '0);
            any_low  = any_low | (lvl_q[i] <= LVL_W'(LOW_THR));
            all_hi   = all_hi & (lvl_q[i] >= LVL_W'(HI_THR));
            if (lvl_q[i] < min_v) begin
                min_v      = lvl_q[i];
                search_idx = IW'(i);
            end
        end
        idx_d  = (state_q == ST_DEATH) ? idx_q : search_idx;
        dcnt_d = !any_zero ? '0 : (tick && dcnt_q != CW'(DEATH_TICKS)) ? dcnt_q + 1'b1 : dcnt_q;
        eval   = any_low ? ST_NEED : all_hi ? ST_IDLE : ST_NEUTRAL;
        state_d = (state_q == ST_DEATH || dcnt_q == CW'(DEATH_TICKS)) ? ST_DEATH :
                  sleeping ? (((wake_req && !sleep_req) || lvl_q[0] == LVL_MAX) ? eval : ST_SLEEP) :
                  (sleep_req && !wake_req) ? ST_SLEEP : eval;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
            for (int i = 0; i < NUM_NEEDS; i++) lvl_q[i] <= LVL_MAX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            for (int i = 0; i < NUM_NEEDS; i++) lvl_q[i] <= lvl_d[i];
        end
    end

    for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_lvl
        assign levels[g*LVL_W +: LVL_W] = lvl_q[g];
    end

    assign state    = state_q;
    assign need_idx = idx_q;
endmodule
